// File: rtl/ss_write_data.sv
// ---------------------------------------------------------------------------
// ss_write_data
//
// BRAM write-side sequencer. A rising edge on i_start_write_data arms a run
// covering addresses i_si_ram .. i_ei_ram inclusive (modulo 2**SIZE_ADDR).
// During the run every accepted valid/ready beat is written into the BRAM
// through a registered write port, one word per beat. After the last word
// has been written, o_done_write_data pulses for a single cycle.
//
// Ports
//   i_clk              clock, rising edge
//   i_rst_n            asynchronous active-low reset
//   i_start_write_data level input; its rising edge starts or restarts a run
//   i_en_write_data    1 = accept beats, 0 = pause the run
//   i_si_ram           first address of the run, sampled on the start edge
//   i_ei_ram           last address of the run, sampled on the start edge
//   i_valid            producer presents a word on i_data
//   i_data             write data
//   o_ready            block accepts a beat this cycle
//   o_we_ram           BRAM write enable (registered)
//   o_addr_ram         BRAM write address (registered)
//   o_data_ram         BRAM write data (registered)
//   o_count            words written in the current / last run
//   o_done_write_data  one-cycle pulse when a run completes
// ---------------------------------------------------------------------------
module ss_write_data #(
    parameter int SIZE_ADDR = 6,
    parameter int SIZE_DATA = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start_write_data,
    input  logic                 i_en_write_data,
    input  logic [SIZE_ADDR-1:0] i_si_ram,
    input  logic [SIZE_ADDR-1:0] i_ei_ram,
    input  logic                 i_valid,
    input  logic [SIZE_DATA-1:0] i_data,
    output logic                 o_ready,
    output logic                 o_we_ram,
    output logic [SIZE_ADDR-1:0] o_addr_ram,
    output logic [SIZE_DATA-1:0] o_data_ram,
    output logic [SIZE_ADDR:0]   o_count,
    output logic                 o_done_write_data
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [SIZE_ADDR-1:0] PTR_ONE = {{(SIZE_ADDR-1){1'b0}}, 1'b1};
    localparam logic [SIZE_ADDR:0]   CNT_ONE = {{SIZE_ADDR{1'b0}}, 1'b1};

    logic [1:0]           r_state;
    logic                 r_start_prev;
    logic [SIZE_ADDR-1:0] r_ptr;
    logic [SIZE_ADDR-1:0] r_end;
    logic [SIZE_ADDR:0]   r_count;
    logic                 r_we;
    logic [SIZE_ADDR-1:0] r_addr;
    logic [SIZE_DATA-1:0] r_data;
    logic                 r_done;

    logic                 w_start_pulse;
    logic                 w_ready;
    logic                 w_beat;
    logic                 w_last;

    // The start pulse is taken straight from the input so a restart is seen
    // in the same cycle it is raised; the history register only remembers
    // the previous level. A start held high through reset release counts as
    // an edge because the history resets to 0.
    assign w_start_pulse = i_start_write_data & ~r_start_prev;

    // A restart always wins over a beat in the same cycle, so ready is
    // masked by the start pulse. Ready never depends on i_valid.
    assign w_ready = (r_state == ST_WRITE) & i_en_write_data & ~w_start_pulse;
    assign w_beat  = i_valid & w_ready;

    // Comparing the pointer against the stored end address (rather than
    // counting words) makes wrap-around runs and the full 2**SIZE_ADDR run
    // (si == ei + 1) fall out naturally.
    assign w_last  = (r_ptr == r_end);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_start_prev <= 1'b0;
            r_ptr        <= '0;
            r_end        <= '0;
            r_count      <= '0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_done       <= 1'b0;
        end else begin
            r_start_prev <= i_start_write_data;
            r_done       <= 1'b0;

            if (w_start_pulse) begin
                // Start or restart from any state. An aborted run gets no
                // done pulse; words already written stay in the BRAM.
                r_ptr   <= i_si_ram;
                r_end   <= i_ei_ram;
                r_count <= '0;
                r_we    <= 1'b0;
                r_state <= ST_WRITE;
            end else begin
                case (r_state)
                    ST_WRITE: begin
                        if (w_beat) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_ptr;
                            r_data  <= i_data;
                            r_ptr   <= r_ptr + PTR_ONE;
                            r_count <= r_count + CNT_ONE;
                            if (w_last) begin
                                r_state <= ST_DONE;
                            end
                        end else begin
                            // Idle beat or paused: address and data hold.
                            r_we <= 1'b0;
                        end
                    end
                    ST_DONE: begin
                        // Done lands one cycle after the last write strobe.
                        r_done  <= 1'b1;
                        r_we    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                    default: begin
                        r_we    <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_ready           = w_ready;
    assign o_we_ram          = r_we;
    assign o_addr_ram        = r_addr;
    assign o_data_ram        = r_data;
    assign o_count           = r_count;
    assign o_done_write_data = r_done;

endmodule

// File: tb/tb_ss_write_data.sv
// ---------------------------------------------------------------------------
// tb_ss_write_data
//
// Bench for ss_write_data. A driver applies inputs on the falling edge and
// updates a run-level reference model (current address, words remaining,
// words written) that predicts o_ready and queues the writes and done pulses
// each rising edge should produce. A separate monitor pops those queues
// whenever the DUT presents a write strobe or a done pulse.
// ---------------------------------------------------------------------------
module tb_ss_write_data;

    localparam int AW = 6;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic          i_clk;
    logic          i_rst_n;
    logic          i_start_write_data;
    logic          i_en_write_data;
    logic [AW-1:0] i_si_ram;
    logic [AW-1:0] i_ei_ram;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_ready;
    logic          o_we_ram;
    logic [AW-1:0] o_addr_ram;
    logic [DW-1:0] o_data_ram;
    logic [AW:0]   o_count;
    logic          o_done_write_data;

    ss_write_data #(.SIZE_ADDR(AW), .SIZE_DATA(DW)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_start_write_data (i_start_write_data),
        .i_en_write_data    (i_en_write_data),
        .i_si_ram           (i_si_ram),
        .i_ei_ram           (i_ei_ram),
        .i_valid            (i_valid),
        .i_data             (i_data),
        .o_ready            (o_ready),
        .o_we_ram           (o_we_ram),
        .o_addr_ram         (o_addr_ram),
        .o_data_ram         (o_data_ram),
        .o_count            (o_count),
        .o_done_write_data  (o_done_write_data)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct {
        int addr;
        logic [DW-1:0] data;
        int cnt;
    } wr_t;

    wr_t q_wr[$];
    int  q_done[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: run-level view
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_FIN  = 2;
    int   m_state = M_IDLE;
    logic m_prev  = 1'b0;
    int   m_addr  = 0;
    int   m_rem   = 0;
    int   m_count = 0;

    int g_si = 0;
    int g_ei = 0;

    // Monitor: sample shortly after each rising edge.
    always @(posedge i_clk) begin
        #2;
        if (i_rst_n) begin
            if (o_we_ram) begin
                n_vec++;
                if (q_wr.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_write: addr=%0d data=%h, no write expected", o_addr_ram, o_data_ram);
                end else begin
                    wr_t e;
                    e = q_wr.pop_front();
                    if (int'(o_addr_ram) != e.addr || o_data_ram !== e.data || int'(o_count) != e.cnt) begin
                        n_err++;
                        $display("FAIL write: got addr=%0d data=%h count=%0d, expected addr=%0d data=%h count=%0d",
                                 o_addr_ram, o_data_ram, o_count, e.addr, e.data, e.cnt);
                    end
                end
            end
            if (o_done_write_data) begin
                n_vec++;
                if (q_done.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_done: count=%0d, no done expected", o_count);
                end else begin
                    int ec;
                    ec = q_done.pop_front();
                    if (int'(o_count) != ec || o_we_ram !== 1'b0) begin
                        n_err++;
                        $display("FAIL done: got count=%0d we=%0b, expected count=%0d we=0", o_count, o_we_ram, ec);
                    end
                end
            end
        end
    end

    // One clock of stimulus plus model update.
    task automatic step(input logic st, input logic en, input logic vl);
        logic [DW-1:0] d;
        logic          pulse;
        logic          er;
        @(negedge i_clk);
        n_vec++;
        if (int'(o_count) != m_count) begin
            n_err++;
            $display("FAIL count: got %0d, expected %0d", o_count, m_count);
        end
        d = $urandom;
        i_start_write_data = st;
        i_en_write_data    = en;
        i_valid            = vl;
        i_data             = d;
        i_si_ram           = AW'(g_si);
        i_ei_ram           = AW'(g_ei);
        #1;
        pulse  = st & ~m_prev;
        m_prev = st;
        er = (m_state == M_RUN) && en && !pulse;
        n_vec++;
        if (o_ready !== er) begin
            n_err++;
            $display("FAIL ready: got %0b, expected %0b", o_ready, er);
        end
        if (pulse) begin
            m_state = M_RUN;
            m_addr  = g_si;
            m_rem   = (((g_ei - g_si) % DEPTH) + DEPTH) % DEPTH + 1;
            m_count = 0;
        end else if (m_state == M_RUN) begin
            if (er && vl) begin
                m_count++;
                q_wr.push_back('{addr: m_addr, data: d, cnt: m_count});
                m_addr = (m_addr + 1) % DEPTH;
                m_rem--;
                if (m_rem == 0) m_state = M_FIN;
            end
        end else if (m_state == M_FIN) begin
            q_done.push_back(m_count);
            m_state = M_IDLE;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_vec++;
        if (o_ready !== 1'b0 || o_we_ram !== 1'b0 || o_addr_ram !== '0 || o_data_ram !== '0 ||
            o_count !== '0 || o_done_write_data !== 1'b0) begin
            n_err++;
            $display("FAIL %s: ready=%0b we=%0b addr=%0d data=%h count=%0d done=%0b, all must be 0",
                     tag, o_ready, o_we_ram, o_addr_ram, o_data_ram, o_count, o_done_write_data);
        end
    endtask

    task automatic apply_reset();
        @(negedge i_clk);
        #2;
        i_start_write_data = 1'b0;
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        m_state = M_IDLE;
        m_prev  = 1'b0;
        m_count = 0;
        q_wr.delete();
        q_done.delete();
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic run_plain(input int si, input int ei, input int ncyc);
        g_si = si;
        g_ei = ei;
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < ncyc; k++) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n = 1'b1;
        i_start_write_data = 1'b0;
        i_en_write_data = 1'b0;
        i_valid = 1'b0;
        i_data = '0;
        i_si_ram = '0;
        i_ei_ram = '0;
        #1;
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_state");
        @(negedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        // Idle: ready stays low with valid/en high
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1);

        // Basic run 3..6
        run_plain(3, 6, 7);
        // Single word
        run_plain(10, 10, 4);
        // Wrap through 0
        run_plain(62, 1, 7);
        // Full-depth run
        run_plain(7, 6, DEPTH + 3);

        // Backpressure: valid toggles, en low for 3 cycles
        g_si = 5; g_ei = 12;
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Restart mid-run; start then held high
        g_si = 0; g_ei = 7;
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1);
        g_si = 20; g_ei = 21;
        for (int k = 0; k < 8; k++) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Restart coinciding with the final beat
        g_si = 0; g_ei = 2;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        g_si = 40; g_ei = 40;
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Async reset mid-run while writing
        g_si = 30; g_ei = 50;
        step(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b1, 1'b1);
        apply_reset();
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1);

        // Randomised traffic
        for (int k = 0; k < 2500; k++) begin
            logic st;
            st = m_prev;
            if ($urandom_range(0, 39) == 0) st = ~st;
            if ($urandom_range(0, 3) == 0) begin
                g_si = int'($urandom_range(0, DEPTH - 1));
                g_ei = int'($urandom_range(0, DEPTH - 1));
            end
            step(st, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) < 7));
        end

        // Drain
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0);
        n_vec++;
        if (q_wr.size() != 0) begin
            n_err++;
            $display("FAIL pending_writes: %0d writes never seen, expected 0", q_wr.size());
        end
        n_vec++;
        if (q_done.size() != 0) begin
            n_err++;
            $display("FAIL pending_done: %0d done pulses never seen, expected 0", q_done.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
